// File: rtl/vec_mul_seq.sv
// Sequencer that time-multiplexes a lanes-wide signed multiplier array over a
// length-element vector pair, one lane-slice per cycle, with valid/ready on both sides.
module vec_mul_seq #(
  parameter int unsigned bit_width = 8,
  parameter int unsigned length    = 32,
  parameter int unsigned lanes     = 8,
  parameter int unsigned prd_width = 2 * bit_width
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic signed [bit_width-1:0] i_vec_a [length],
  input  logic signed [bit_width-1:0] i_vec_b [length],
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic signed [prd_width-1:0] o_prd   [length]
);

  localparam int unsigned beats  = length / lanes;
  localparam int unsigned beat_w = (beats > 1) ? $clog2(beats) : 1;
  localparam int unsigned idx_w  = (length > 1) ? $clog2(length) : 1;
  localparam int unsigned mul_w  = 2 * bit_width;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  if (length % lanes != 0) begin : g_len_chk
    $error("vec_mul_seq: length must be a multiple of lanes");
  end

  logic [1:0]                  state_q, state_d;
  logic [beat_w-1:0]           beat_q, beat_d;
  logic                        ready_q, ready_d;
  logic                        valid_q, valid_d;
  logic signed [bit_width-1:0] a_q   [length];
  logic signed [bit_width-1:0] a_d   [length];
  logic signed [bit_width-1:0] b_q   [length];
  logic signed [bit_width-1:0] b_d   [length];
  logic signed [prd_width-1:0] prd_q [length];
  logic signed [prd_width-1:0] prd_d [length];

  logic [idx_w-1:0]            idx_c  [lanes];
  logic signed [mul_w-1:0]     prod_c [lanes];

  // Elementwise signed multiplier array over the current beat's slice.
  always_comb begin
    for (int j = 0; j < int'(lanes); j++) begin
      idx_c[j]  = idx_w'(beat_q) * idx_w'(lanes) + idx_w'(j);
      prod_c[j] = mul_w'(a_q[idx_c[j]]) * mul_w'(b_q[idx_c[j]]);
    end
  end

  // Next-state, operand capture and result write-back.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    a_d     = a_q;
    b_d     = b_q;
    prd_d   = prd_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          a_d     = i_vec_a;
          b_d     = i_vec_b;
          beat_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int j = 0; j < int'(lanes); j++) begin
          prd_d[idx_c[j]] = prd_width'(prod_c[j]);
        end
        if (beat_q == beat_w'(beats - 1)) begin
          beat_d  = '0;
          state_d = ST_DONE;
        end else begin
          beat_d = beat_q + beat_w'(1);
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Handshake flags track the next state so they are pure state decodes.
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      for (int i = 0; i < int'(length); i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        prd_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prd_q   <= prd_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_prd   = prd_q;

endmodule

// File: tb/tb_vec_mul_seq.sv
// Self-checking bench for vec_mul_seq: random vector pairs checked against a
// plain-arithmetic product model, plus handshake, latency and reset scenarios.
module tb_vec_mul_seq;

  localparam int unsigned BW    = 8;
  localparam int unsigned LEN   = 32;
  localparam int unsigned LANES = 8;
  localparam int unsigned PW    = 16;
  localparam int unsigned BEATS = LEN / LANES;

  logic clk = 1'b0;
  logic rst_n;
  logic i_valid;
  logic i_ready;
  logic o_ready;
  logic o_valid;
  logic signed [BW-1:0] vec_a [LEN];
  logic signed [BW-1:0] vec_b [LEN];
  logic signed [PW-1:0] prd   [LEN];

  int exp_a [LEN];
  int exp_b [LEN];
  int n_chk  = 0;
  int n_pass = 0;

  vec_mul_seq #(
    .bit_width(BW),
    .length   (LEN),
    .lanes    (LANES),
    .prd_width(PW)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_vec_a(vec_a),
    .i_vec_b(vec_b),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_prd  (prd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vecs();
    for (int i = 0; i < int'(LEN); i++) begin
      vec_a[i] = BW'($urandom);
      vec_b[i] = BW'($urandom);
    end
  endtask

  // Reference: each element's product is the plain integer product of the pair.
  task automatic latch_model();
    for (int i = 0; i < int'(LEN); i++) begin
      exp_a[i] = int'(vec_a[i]);
      exp_b[i] = int'(vec_b[i]);
    end
  endtask

  task automatic check_prd(input string tag);
    for (int i = 0; i < int'(LEN); i++)
      check(tag, 32'(prd[i]), 32'(exp_a[i] * exp_b[i]));
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < int'(LEN); i++)
      check(tag, 32'(prd[i]), 32'(0));
  endtask

  // Accept the current vectors from IDLE and wait for the result.
  task automatic run_vec(input string tag);
    int lat;
    check({tag, "_rdy"}, 32'(o_ready), 32'(1));
    latch_model();
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(BEATS));
    check_prd(tag);
  endtask

  task automatic release_result(input string tag);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check({tag, "_idle_rdy"}, 32'(o_ready), 32'(1));
    check({tag, "_idle_vld"}, 32'(o_valid), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int results;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    for (int i = 0; i < int'(LEN); i++) begin
      vec_a[i] = '0;
      vec_b[i] = '0;
    end

    // Reset state, then unchanged after release
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", 32'(o_ready), 32'(1));
    check("rst_vld", 32'(o_valid), 32'(0));
    check_zero("rst_prd");
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_rdy", 32'(o_ready), 32'(1));
    check("post_rst_vld", 32'(o_valid), 32'(0));
    check_zero("post_rst_prd");

    // Basic ramp times two, with backpressure hold
    for (int i = 0; i < int'(LEN); i++) begin
      vec_a[i] = BW'(i);
      vec_b[i] = BW'(2);
    end
    run_vec("basic");
    check("basic_e31", 32'(prd[31]), 32'(62));
    repeat (5) begin
      tick();
      check("hold_vld", 32'(o_valid), 32'(1));
      check("hold_rdy", 32'(o_ready), 32'(0));
    end
    check_prd("hold");
    release_result("basic");

    // Signed extremes, one per beat
    rand_vecs();
    vec_a[0]  = BW'(-128); vec_b[0]  = BW'(-128);
    vec_a[9]  = BW'(-128); vec_b[9]  = BW'(127);
    vec_a[18] = BW'(127);  vec_b[18] = BW'(127);
    vec_a[31] = BW'(-1);   vec_b[31] = BW'(1);
    run_vec("ext");
    check("ext_e0",  32'(prd[0]),  32'(16384));
    check("ext_e9",  32'(prd[9]),  32'(-16256));
    check("ext_e18", 32'(prd[18]), 32'(16129));
    check("ext_e31", 32'(prd[31]), 32'(-1));
    release_result("ext");

    // Input isolation during RUN and DONE
    rand_vecs();
    latch_model();
    i_valid = 1'b1;
    tick();
    lat = 0;
    while (!o_valid && lat < 20) begin
      check("iso_run_rdy", 32'(o_ready), 32'(0));
      rand_vecs();
      i_valid = ~i_valid;
      tick();
      lat++;
    end
    check("iso_lat", 32'(lat), 32'(BEATS));
    repeat (3) begin
      check("iso_done_rdy", 32'(o_ready), 32'(0));
      check("iso_done_vld", 32'(o_valid), 32'(1));
      rand_vecs();
      i_valid = ~i_valid;
      tick();
    end
    check_prd("iso");
    i_valid = 1'b0;
    release_result("iso");
    tick();
    check("iso_no_reaccept", 32'(o_ready), 32'(1));
    check_prd("iso_keep");

    // Asynchronous reset during beat 2
    rand_vecs();
    latch_model();
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst_vld", 32'(o_valid), 32'(0));
    check("mrst_rdy", 32'(o_ready), 32'(1));
    check_zero("mrst_prd");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < int'(LEN); i++) begin
      vec_a[i] = BW'(3);
      vec_b[i] = BW'(3);
    end
    run_vec("three");
    check("three_e31", 32'(prd[31]), 32'(9));
    release_result("three");

    // Back-to-back streaming: accept every BEATS+2 cycles
    results = 0;
    rand_vecs();
    i_valid = 1'b1;
    i_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      check("b2b_rdy", 32'(o_ready), 32'(c % 6 == 0));
      check("b2b_vld", 32'(o_valid), 32'(c % 6 == 5));
      if (c % 6 == 5) begin
        check_prd("b2b_prd");
        results++;
      end
      if (c % 6 == 0) latch_model();
      tick();
      if (c % 6 == 0) rand_vecs();
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    check("b2b_results", 32'(results), 32'(10));
    check("b2b_end_rdy", 32'(o_ready), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
